// File: rtl/cdb_pkg.sv
// Shared types and helpers for the CDB result-bus arbiter.
package cdb_pkg;

    localparam int unsigned CDB_TAG_W  = 4;
    localparam int unsigned CDB_DATA_W = 32;

    // Tag 0 means "no producer" and is never broadcast.
    localparam logic [CDB_TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] wdata;
    } cdb_pkt_t;

    // Round-robin pointer advance; wraps explicitly so N need not be a power of two.
    function automatic int unsigned ptr_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational one-hot picker: first set request at or after 'start', wrapping modulo N.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] start,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] id
);

    logic [ID_W:0] idx;
    logic          found;

    // Scan N positions starting at 'start'; first hit wins.
    always_comb begin
        gnt   = '0;
        id    = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = {1'b0, start} + (ID_W + 1)'(k);
            // start is always < N, so a single subtraction completes the wrap.
            if (idx >= (ID_W + 1)'(N)) begin
                idx = idx - (ID_W + 1)'(N);
            end
            if (!found && req[idx[ID_W-1:0]]) begin
                found                = 1'b1;
                gnt[idx[ID_W-1:0]]   = 1'b1;
                id                   = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cdb_arb.sv
// Result-bus arbiter: per-EXU one-entry holding slots, one winner per cycle onto a
// registered CDB broadcast. Define CDB_ARB_FIXED_PRI_EN for fixed priority (index 0
// highest, no round-robin pointer); the default build is round-robin.
module cdb_arb
    import cdb_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              exu_req,
    input  logic [N_REQ-1:0][TAG_W-1:0]   exu_tag,
    input  logic [N_REQ-1:0][DATA_W-1:0]  exu_wdata,
    output logic [N_REQ-1:0]              exu_rdy,
    output logic                          cdb_wr,
    output logic [TAG_W-1:0]              cdb_tag,
    output logic [DATA_W-1:0]             cdb_wdata,
    output logic [ID_W-1:0]               cdb_gnt_id
);

    logic [N_REQ-1:0]             hold_vld_q, hold_vld_d;
    logic [N_REQ-1:0][TAG_W-1:0]  hold_tag_q, hold_tag_d;
    logic [N_REQ-1:0][DATA_W-1:0] hold_data_q, hold_data_d;
    logic [N_REQ-1:0]             gnt;
    logic [ID_W-1:0]              win_id;
    logic [ID_W-1:0]              pick_start;

`ifdef CDB_ARB_FIXED_PRI_EN
    assign pick_start = '0;
`else
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    assign pick_start = rr_ptr_q;

    // Pointer moves to the slot after the winner; unchanged when nothing is granted.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (|gnt) begin
            rr_ptr_d = ID_W'(ptr_inc(32'(win_id), N_REQ));
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Grant depends only on held slots and the pointer, never on exu_req.
    rr_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req   (hold_vld_q),
        .start (pick_start),
        .gnt   (gnt),
        .id    (win_id)
    );

    // A granted slot frees up this cycle, so it can take a new result immediately.
    assign exu_rdy = {N_REQ{~rst}} & (~hold_vld_q | gnt);

    // Slot next-state: a new capture beats a same-cycle grant; tag 0 is swallowed.
    always_comb begin
        hold_vld_d  = hold_vld_q;
        hold_tag_d  = hold_tag_q;
        hold_data_d = hold_data_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (exu_req[i] && exu_rdy[i] && (exu_tag[i] != TAG_W'(TAG_NONE))) begin
                hold_vld_d[i]  = 1'b1;
                hold_tag_d[i]  = exu_tag[i];
                hold_data_d[i] = exu_wdata[i];
            end else if (gnt[i]) begin
                hold_vld_d[i] = 1'b0;
            end
        end
    end

    // Holding slots and CDB output registers; payload holds its last value when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld_q  <= '0;
            hold_tag_q  <= '0;
            hold_data_q <= '0;
            cdb_wr      <= 1'b0;
            cdb_tag     <= '0;
            cdb_wdata   <= '0;
            cdb_gnt_id  <= '0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            hold_tag_q  <= hold_tag_d;
            hold_data_q <= hold_data_d;
            cdb_wr      <= |gnt;
            if (|gnt) begin
                cdb_tag    <= hold_tag_q[win_id];
                cdb_wdata  <= hold_data_q[win_id];
                cdb_gnt_id <= win_id;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arb.sv
// Directed self-checking bench for cdb_arb (4 ports, 4-bit tags, 32-bit data).
module tb_cdb_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned TW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N-1:0]           exu_req;
    logic [N-1:0][TW-1:0]   exu_tag;
    logic [N-1:0][DW-1:0]   exu_wdata;
    logic [N-1:0]           exu_rdy;
    logic                   cdb_wr;
    logic [TW-1:0]          cdb_tag;
    logic [DW-1:0]          cdb_wdata;
    logic [IW-1:0]          cdb_gnt_id;

    int n_vec = 0;
    int n_err = 0;

    cdb_arb #(
        .N_REQ  (N),
        .TAG_W  (TW),
        .DATA_W (DW),
        .ID_W   (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .exu_req    (exu_req),
        .exu_tag    (exu_tag),
        .exu_wdata  (exu_wdata),
        .exu_rdy    (exu_rdy),
        .cdb_wr     (cdb_wr),
        .cdb_tag    (cdb_tag),
        .cdb_wdata  (cdb_wdata),
        .cdb_gnt_id (cdb_gnt_id)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are then stable for checking.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        exu_req   = '0;
        exu_tag   = '0;
        exu_wdata = '0;
        tick();
        tick();
        n_vec++;
        if ({cdb_wr, cdb_tag, cdb_wdata, cdb_gnt_id} !== 39'd0) begin
            n_err++;
            $display("FAIL reset_cdb: got %h want 0", {cdb_wr, cdb_tag, cdb_wdata, cdb_gnt_id});
        end
        n_vec++;
        if (exu_rdy !== 4'h0) begin
            n_err++;
            $display("FAIL reset_rdy: got %b want 0000", exu_rdy);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (exu_rdy !== 4'hF) begin
            n_err++;
            $display("FAIL post_reset_rdy: got %b want 1111", exu_rdy);
        end
    endtask

    task automatic test_burst();
        logic [5:0] m;
        // First burst: tags 1..4 from rr_ptr=0.
        for (int i = 0; i < 4; i++) begin
            exu_req[i]   = 1'b1;
            exu_tag[i]   = 4'(i + 1);
            exu_wdata[i] = 32'h1000_0000 + 32'(i);
        end
        tick();
        exu_req = '0;
        n_vec++;
        if (cdb_wr !== 1'b0) begin
            n_err++;
            $display("FAIL burst_capture_wr: got %b want 0", cdb_wr);
        end
        n_vec++;
        if (exu_rdy !== 4'b0001) begin
            n_err++;
            $display("FAIL burst_capture_rdy: got %b want 0001", exu_rdy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if ({cdb_wr, cdb_tag, cdb_wdata, cdb_gnt_id} !==
                {1'b1, 4'(i + 1), 32'h1000_0000 + 32'(i), 2'(i)}) begin
                n_err++;
                $display("FAIL burst1_bcast%0d: got wr=%b tag=%0d data=%h id=%0d want tag=%0d id=%0d",
                         i, cdb_wr, cdb_tag, cdb_wdata, cdb_gnt_id, i + 1, i);
            end
            m = (6'd1 << (i + 2)) - 6'd1;
            n_vec++;
            if (exu_rdy !== m[3:0]) begin
                n_err++;
                $display("FAIL burst1_rdy%0d: got %b want %b", i, exu_rdy, m[3:0]);
            end
        end
        // Second burst: pointer has wrapped from 3 back to 0.
        for (int i = 0; i < 4; i++) begin
            exu_req[i]   = 1'b1;
            exu_tag[i]   = 4'(i + 9);
            exu_wdata[i] = 32'h2000_0000 + 32'(i);
        end
        tick();
        exu_req = '0;
        n_vec++;
        if (cdb_wr !== 1'b0) begin
            n_err++;
            $display("FAIL burst2_gap_wr: got %b want 0", cdb_wr);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if ({cdb_wr, cdb_tag, cdb_wdata, cdb_gnt_id} !==
                {1'b1, 4'(i + 9), 32'h2000_0000 + 32'(i), 2'(i)}) begin
                n_err++;
                $display("FAIL burst2_bcast%0d: got wr=%b tag=%0d data=%h id=%0d want tag=%0d id=%0d",
                         i, cdb_wr, cdb_tag, cdb_wdata, cdb_gnt_id, i + 9, i);
            end
        end
        tick();
        n_vec++;
        if ({cdb_wr, cdb_tag, cdb_wdata, cdb_gnt_id} !== {1'b0, 4'd12, 32'h2000_0003, 2'd3}) begin
            n_err++;
            $display("FAIL burst_idle_hold: got wr=%b tag=%0d data=%h id=%0d want 0/12/20000003/3",
                     cdb_wr, cdb_tag, cdb_wdata, cdb_gnt_id);
        end
    endtask

    task automatic test_single();
        exu_req[2]   = 1'b1;
        exu_tag[2]   = 4'd5;
        exu_wdata[2] = 32'hDEAD_BEEF;
        n_vec++;
        if (exu_rdy[2] !== 1'b1) begin
            n_err++;
            $display("FAIL single_rdy: got %b want 1", exu_rdy[2]);
        end
        tick();
        exu_req = '0;
        n_vec++;
        if (cdb_wr !== 1'b0) begin
            n_err++;
            $display("FAIL single_early_wr: got %b want 0", cdb_wr);
        end
        tick();
        n_vec++;
        if ({cdb_wr, cdb_tag, cdb_wdata, cdb_gnt_id} !== {1'b1, 4'd5, 32'hDEAD_BEEF, 2'd2}) begin
            n_err++;
            $display("FAIL single_bcast: got wr=%b tag=%0d data=%h id=%0d want 1/5/deadbeef/2",
                     cdb_wr, cdb_tag, cdb_wdata, cdb_gnt_id);
        end
        tick();
        n_vec++;
        if (cdb_wr !== 1'b0) begin
            n_err++;
            $display("FAIL single_pulse_width: got %b want 0", cdb_wr);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                exu_req[1]   = 1'b1;
                exu_tag[1]   = 4'(k + 1);
                exu_wdata[1] = 32'hA000_0000 + 32'(k);
                n_vec++;
                if (exu_rdy[1] !== 1'b1) begin
                    n_err++;
                    $display("FAIL stream_rdy%0d: got %b want 1", k, exu_rdy[1]);
                end
            end else begin
                exu_req = '0;
            end
            if (k >= 2) begin
                n_vec++;
                if ({cdb_wr, cdb_tag, cdb_wdata, cdb_gnt_id} !==
                    {1'b1, 4'(k - 1), 32'hA000_0000 + 32'(k - 2), 2'd1}) begin
                    n_err++;
                    $display("FAIL stream_bcast%0d: got wr=%b tag=%0d data=%h id=%0d want tag=%0d id=1",
                             k - 2, cdb_wr, cdb_tag, cdb_wdata, cdb_gnt_id, k - 1);
                end
            end
            tick();
        end
        n_vec++;
        if (cdb_wr !== 1'b0) begin
            n_err++;
            $display("FAIL stream_end_wr: got %b want 0", cdb_wr);
        end
    endtask

    task automatic test_tag_zero();
        exu_req[3]   = 1'b1;
        exu_tag[3]   = 4'd0;
        exu_wdata[3] = 32'h5555_5555;
        n_vec++;
        if (exu_rdy[3] !== 1'b1) begin
            n_err++;
            $display("FAIL tag0_rdy: got %b want 1", exu_rdy[3]);
        end
        tick();
        exu_req = '0;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (cdb_wr !== 1'b0) begin
                n_err++;
                $display("FAIL tag0_no_bcast%0d: got %b want 0", i, cdb_wr);
            end
            tick();
        end
        n_vec++;
        if (exu_rdy !== 4'hF) begin
            n_err++;
            $display("FAIL tag0_slot_empty: got %b want 1111", exu_rdy);
        end
    endtask

    task automatic test_reset_mid();
        exu_req      = 4'b0011;
        exu_tag[0]   = 4'd6;
        exu_tag[1]   = 4'd7;
        exu_wdata[0] = 32'h6666_0000;
        exu_wdata[1] = 32'h7777_0000;
        tick();
        exu_req = '0;
        rst     = 1'b1;
        #1;
        n_vec++;
        if (exu_rdy !== 4'h0) begin
            n_err++;
            $display("FAIL midrst_rdy_during: got %b want 0000", exu_rdy);
        end
        tick();
        n_vec++;
        if ({cdb_wr, cdb_tag, cdb_wdata, cdb_gnt_id} !== 39'd0) begin
            n_err++;
            $display("FAIL midrst_cdb: got wr=%b tag=%0d data=%h id=%0d want all 0",
                     cdb_wr, cdb_tag, cdb_wdata, cdb_gnt_id);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (exu_rdy !== 4'hF) begin
            n_err++;
            $display("FAIL midrst_rdy_after: got %b want 1111", exu_rdy);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (cdb_wr !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_stale%0d: got %b want 0", i, cdb_wr);
            end
        end
        // Pointer was 2 before reset; port 0 must now win over port 3.
        exu_req      = 4'b1001;
        exu_tag[0]   = 4'd1;
        exu_tag[3]   = 4'd3;
        exu_wdata[0] = 32'h0000_00A0;
        exu_wdata[3] = 32'h0000_00A3;
        tick();
        exu_req = '0;
        tick();
        n_vec++;
        if ({cdb_wr, cdb_tag, cdb_gnt_id} !== {1'b1, 4'd1, 2'd0}) begin
            n_err++;
            $display("FAIL midrst_ptr_first: got wr=%b tag=%0d id=%0d want 1/1/0",
                     cdb_wr, cdb_tag, cdb_gnt_id);
        end
        tick();
        n_vec++;
        if ({cdb_wr, cdb_tag, cdb_gnt_id} !== {1'b1, 4'd3, 2'd3}) begin
            n_err++;
            $display("FAIL midrst_ptr_second: got wr=%b tag=%0d id=%0d want 1/3/3",
                     cdb_wr, cdb_tag, cdb_gnt_id);
        end
        tick();
    endtask

`ifdef CDB_ARB_FIXED_PRI_EN
    task automatic test_fixed_pri();
        exu_req    = 4'b0011;
        exu_tag[0] = 4'd1;
        exu_tag[1] = 4'd2;
        tick();
        exu_req[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_vec++;
            if ({cdb_wr, cdb_gnt_id, exu_rdy[1]} !== {1'b1, 2'd0, 1'b0}) begin
                n_err++;
                $display("FAIL fixed_starve%0d: got wr=%b id=%0d rdy1=%b want 1/0/0",
                         i, cdb_wr, cdb_gnt_id, exu_rdy[1]);
            end
        end
        exu_req = '0;
        tick();
        tick();
        n_vec++;
        if ({cdb_wr, cdb_tag, cdb_gnt_id} !== {1'b1, 4'd2, 2'd1}) begin
            n_err++;
            $display("FAIL fixed_release: got wr=%b tag=%0d id=%0d want 1/2/1",
                     cdb_wr, cdb_tag, cdb_gnt_id);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_burst();
        test_single();
        test_back_to_back();
        test_tag_zero();
        test_reset_mid();
`ifdef CDB_ARB_FIXED_PRI_EN
        test_fixed_pri();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_arb.md
# cdb_arb

Result-bus arbiter between the execution units and the common data bus (CDB). Each EXU hands its finished result (tag, data) to a private one-entry holding slot. A round-robin arbiter picks one occupied slot per cycle and drives it onto a registered CDB broadcast, which every reservation station and the register file snoop. This block lets several EXUs share the single CDB without losing results.

## Interface
Parameters:
- N_REQ, 4, number of EXU requesters (≥2; need not be a power of two)
- TAG_W, 4, CDB tag width; tag 0 means "no producer" and is never broadcast
- DATA_W, 32, result width
- ID_W, $clog2(N_REQ), grant index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- exu_req  in  N_REQ  per-port result valid
- exu_tag  in  [N_REQ][TAG_W]  per-port destination tag
- exu_wdata  in  [N_REQ][DATA_W]  per-port result data
- exu_rdy  out  N_REQ  per-port slot can accept this cycle
- cdb_wr  out  1  CDB broadcast valid (registered)
- cdb_tag  out  TAG_W  broadcast tag (registered)
- cdb_wdata  out  DATA_W  broadcast data (registered)
- cdb_gnt_id  out  ID_W  port index of the current broadcast (registered)

## Operation
- Per port i there is a holding slot: hold_vld[i], hold_tag[i], hold_data[i].
- Accept: when exu_req[i] && exu_rdy[i], capture tag/data and set hold_vld[i] at the clock edge.
  - A tag of 0 is accepted, dropped, and never sets hold_vld.
- Arbitration is combinational over hold_vld and rr_ptr only. There is no path from exu_req to exu_rdy or to the grant.
  - Search starts at index rr_ptr and wraps modulo N_REQ.
  - The first set hold_vld wins: gnt is one-hot, or zero when all slots are empty.
- Grant at an edge:
  - cdb_wr<=1, cdb_tag<=hold_tag[w], cdb_wdata<=hold_data[w], cdb_gnt_id<=w.
  - hold_vld[w] clears unless refilled in the same cycle.
  - rr_ptr<=(w+1) wrapped, explicitly, to 0 at N_REQ.
- No grant: cdb_wr<=0; cdb_tag/cdb_wdata/cdb_gnt_id hold their last values; rr_ptr unchanged.
- exu_rdy[i] = ~rst && (~hold_vld[i] || gnt[i]).
  - A granted slot accepts a new result in the same cycle, so one port can sustain 1 result/cycle when it is alone.
- Simultaneous grant and refill on the same slot: the new capture wins, so hold_vld stays 1 with the new data.
- The CDB is never back-pressured. Each broadcast lasts exactly one cycle.

## Timing
- Reset values:
  - Outputs: cdb_wr=0, cdb_tag=0, cdb_wdata=0, cdb_gnt_id=0, exu_rdy=0 while rst is high.
  - Internal: all hold_vld=0, rr_ptr=0.
- Reset mid-operation discards all held results. exu_rdy is all-ones the first cycle after rst deasserts.
- Latency: exu_req accepted at edge E → cdb_wr high in the cycle after edge E+1, when uncontended.
- Contention: with K occupied slots, each slot is granted within K cycles. No starvation.
- Throughput: 1 broadcast/cycle aggregate.

## Configuration
- CDB_ARB_FIXED_PRI_EN defined: fixed priority, index 0 highest. rr_ptr is removed and the search always starts at 0. Starvation is permitted; integration guarantees EXU 0 is the long-latency unit.
- Undefined (default): round-robin as described above.

## Structure
- Package cdb_pkg holds:
  - cdb_pkt_t (tag, wdata).
  - localparam TAG_NONE = '0.
  - A function for the wrapping increment of the pointer.
- Sub-module rr_pick: combinational one-hot picker. Inputs are a request vector and a start index; outputs are one-hot gnt and an encoded winner id. The fixed-priority build ties start to 0.
- cdb_arb owns the holding slots, rr_ptr and the CDB output registers.

## Test plan
- Single port: port 2 sends tag 5/0xDEAD_BEEF → cdb_wr=1, cdb_tag=5, cdb_wdata=0xDEADBEEF, cdb_gnt_id=2 exactly two edges later, with one-cycle pulse width.
- All 4 ports request at the same edge with tags 1–4, rr_ptr=0 → broadcasts tags 1,2,3,4 on consecutive cycles.
  - Next simultaneous burst: order starts at port 0 again, because rr_ptr wrapped from 3.
- Port 1 streams 8 back-to-back results with no other traffic → exu_rdy[1] stays 1 and 8 consecutive broadcasts appear in order.
- Port 3 presents tag 0 → accepted (exu_rdy=1) and cdb_wr never asserts for it.
- Ports 0 and 1 held, rst pulsed for one cycle → cdb_wr=0 and exu_rdy=0 during reset. Afterwards no stale broadcast, and rr_ptr=0.
- With CDB_ARB_FIXED_PRI_EN defined: port 0 requests continuously while port 1 holds one result → port 1 is never granted. Drop port 0 → port 1 is granted on the next cycle.
